pe_out_collector: RTL and testbench
===================================

# pe_out_collector

Downstream companion of the fixed-latency 2-in/1-out processing element. It carries a valid token through a delay line matched to the PE pipeline, captures `data_out_1` on exactly the cycles that hold a real result, and buffers those results in a first-word-fall-through (FWFT) FIFO. The FIFO exposes a valid/ready output to the next stage. Results that arrive while the FIFO is full are dropped and flagged.

## Interface
- `WIDTH`, 16: data width; must equal the PE `WIDTH`.
- `LATENCY`, 15: PE pipeline depth in registers; ≥1; must equal the PE `LATENCY`.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  high in the same cycle the PE samples a real operand pair on `data_in_1`/`data_in_2`.
- `pe_data`  in  WIDTH  connects to PE `data_out_1`.
- `clr_ovf`  in  1  clears the sticky `overflow` flag.
- `out_data`  out  WIDTH  FIFO head; reads 0 when the FIFO is empty.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the head.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `overflow`  out  1  sticky; set when a result is dropped.

## Operation
- **Delay line:** `vld_sr[LATENCY-1:0]`.
  - Each edge: `vld_sr[0] <= in_valid`, `vld_sr[i] <= vld_sr[i-1]`.
  - `cap = vld_sr[LATENCY-1]` is aligned with the PE output.
- **Push:** `push = cap`.
  - If `full` and no pop occurs this cycle, the data is dropped and `overflow` is set.
- **Pop:** `pop = out_valid & out_ready`.
- **Simultaneous push and pop:**
  - When full: both proceed and `count` is unchanged.
  - When empty: no bypass. The pop cannot occur because `out_valid` = 0, so only the push lands.
- **Storage:**
  - `mem[DEPTH]`, with `wr_ptr` and `rd_ptr` each $clog2(DEPTH) bits wide; pointers wrap modulo DEPTH.
  - `count` is kept as a separate register, so full and empty are never ambiguous.
- **Overflow flag:**
  - Set on a drop; `clr_ovf` clears it.
  - A drop and `clr_ovf` in the same cycle leave the flag set (set wins).
- **Reset** (`rst` = 0 at an edge):
  - `vld_sr` = 0, pointers = 0, `count` = 0, `overflow` = 0, and the drop counter (when present) = 0.
  - Outputs after reset: `out_valid` = 0, `out_data` = 0, `empty` = 1, `full` = 0.
  - `in_valid` is ignored while reset is held.
  - A reset mid-operation discards all in-flight tokens and all buffered entries. Results that the PE later emits for pre-reset tokens are never captured.
- **No back-pressure to the PE:** the PE has no stall, so the producer is responsible for rate-limiting against `count`.

## Timing
- `in_valid` high in cycle c → `pe_data` is written into the FIFO at the edge ending cycle c+LATENCY → `out_valid` is high from cycle c+LATENCY+1.
  - With LATENCY=15, `in_valid` in cycle 0 gives `out_valid` in cycle 16.
- FIFO read latency is 0 (FWFT): `out_data` is valid whenever `out_valid` is high.
- After a pop, the next entry appears in the following cycle.
- `full`, `empty`, `count` and `overflow` are registered-state derived, with no combinational path from `out_ready`.
- Throughput: one capture per cycle and one pop per cycle, sustained.

## Configuration
- Macro `PE_COLLECT_DROP_CNT_EN`.
- **When defined:** adds output `drop_cnt [15:0]`.
  - Increments on every dropped result and saturates at 16'hFFFF.
  - Cleared only by reset; `clr_ovf` does not affect it.
- **When undefined:** the port and its counter are absent; `overflow` alone reports drops.

## Test plan
All scenarios use WIDTH=16, LATENCY=15, DEPTH=8, driving `pe_data` from a live PE instance.
- **Reset:** hold `rst` = 0 for 3 cycles while driving `in_valid` = 1.
  - After release: `out_valid` = 0, `empty` = 1, `count` = 0, `overflow` = 0.
  - No capture at cycle 16 or later.
- **Single token:** inputs 16'h00F0 | 16'h0F00 with `in_valid` in cycle 0 and `out_ready` = 1.
  - `out_valid` rises in cycle 16 with `out_data` = 16'h0FF0.
  - One beat only, then `empty` = 1.
- **Burst with stall:** 8 back-to-back tokens carrying values 1..8, with `out_ready` = 0.
  - `full` = 1 and `count` = 8, with no overflow.
  - Then raising `out_ready` drains 1..8 in order, one per cycle, exercising pointer wrap.
- **Overflow:** 10 back-to-back tokens with `out_ready` = 0.
  - Tokens 9 and 10 are dropped; `overflow` = 1 and `drop_cnt` = 2 (macro defined).
  - `clr_ovf` pulse sets `overflow` to 0 while `drop_cnt` stays 2.
- **Full with simultaneous push/pop:** FIFO full, `out_ready` = 1, and a new token arriving in the same cycle.
  - `count` stays 8 and the new value is appended last, with no drop.
- **Reset mid-flight:** 4 tokens issued, then `rst` = 0 for 1 cycle at cycle 5.
  - No output ever appears for those tokens.
  - A fresh token after release appears exactly LATENCY+1 cycles later.

Source files
------------

// File: rtl/pe_out_collector_if.sv
// Handshake bundle between the PE-side producer, pe_out_collector and the downstream consumer.
// The drop_cnt signal exists only when PE_COLLECT_DROP_CNT_EN is defined.
interface pe_out_collector_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    logic                     in_valid;
    logic [WIDTH-1:0]         pe_data;
    logic                     clr_ovf;
    logic [WIDTH-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
`ifdef PE_COLLECT_DROP_CNT_EN
    logic [15:0]              drop_cnt;
`endif

    // Master: producer/consumer side that drives tokens and accepts results.
    modport master (
        output in_valid,
        output pe_data,
        output clr_ovf,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  full,
        input  empty,
        input  count,
        input  overflow
`ifdef PE_COLLECT_DROP_CNT_EN
        ,
        input  drop_cnt
`endif
    );

    modport slave (
        input  in_valid,
        input  pe_data,
        input  clr_ovf,
        input  out_ready,
        output out_data,
        output out_valid,
        output full,
        output empty,
        output count,
        output overflow
`ifdef PE_COLLECT_DROP_CNT_EN
        ,
        output drop_cnt
`endif
    );
endinterface

// File: rtl/pe_out_collector.sv
// Carries a valid token alongside the fixed-latency PE and buffers its real results in an FWFT FIFO.
// Optional macro PE_COLLECT_DROP_CNT_EN adds a saturating 16-bit drop counter (bus.drop_cnt).
module pe_out_collector #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 15,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    pe_out_collector_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [LATENCY-1:0] vld_sr;
    logic               cap;
    logic               pop;
    logic               push_ok;
    logic               drop;
    logic               full_w;
    logic               empty_w;

    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic               overflow_reg;

    logic [WIDTH-1:0]   mem [DEPTH];

    // Token delay line: one stage per PE register so cap lines up with pe_data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_sr[0] <= 1'b0;
        end else begin
            vld_sr[0] <= bus.in_valid;
        end
    end

    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vld_stage
        always_ff @(posedge clk) begin
            if (!rst) begin
                vld_sr[gi] <= 1'b0;
            end else begin
                vld_sr[gi] <= vld_sr[gi-1];
            end
        end
    end

    assign cap     = vld_sr[LATENCY-1];
    assign empty_w = (count_reg == '0);
    assign full_w  = (count_reg == CW'(DEPTH));

    // A full FIFO can still accept when the head leaves in the same cycle.
    assign pop     = !empty_w && bus.out_ready;
    assign push_ok = cap && (!full_w || pop);
    assign drop    = cap && full_w && !pop;

    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wr_ptr_reg] <= bus.pe_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            // A drop in the same cycle as clr_ovf must stay visible.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (bus.clr_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

`ifdef PE_COLLECT_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign bus.drop_cnt = drop_cnt_reg;
`endif

    // Shallow FIFO read straight from the array gives the zero-latency head.
    assign bus.out_data  = empty_w ? '0 : mem[rd_ptr_reg];
    assign bus.out_valid = !empty_w;
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
    assign bus.count     = count_reg;
    assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_pe_out_collector.sv
// Bench for pe_out_collector: a stand-in PE (a+b through LATENCY registers) feeds the collector,
// and a queue-based reference model of tokens, FIFO contents and drop flags is checked every cycle.
module tb_pe_out_collector;
    localparam int WIDTH = 16;
    localparam int LAT   = 15;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] pe_pipe [LAT];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    logic [WIDTH-1:0] q [$];
    int               pend_due [$];
    logic [WIDTH-1:0] pend_val [$];
    logic             m_ovf   = 1'b0;
    int               m_drops = 0;

    pe_out_collector_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pe_out_collector #(.WIDTH(WIDTH), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in PE: no stall, no reset, computes every cycle whether or not the operands are real.
    always @(posedge clk) begin
        pe_pipe[0] <= a + b;
        for (int i = 1; i < LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
    end
    assign bus.pe_data = pe_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic compare_all();
        logic [WIDTH-1:0] exp_data;
        exp_data = (q.size() != 0) ? q[0] : '0;
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check("out_data",  32'(bus.out_data),  32'(exp_data));
        check("count",     32'(bus.count),     32'(q.size()));
        check("full",      32'(bus.full),      32'(q.size() == DEPTH));
        check("empty",     32'(bus.empty),     32'(q.size() == 0));
        check("overflow",  32'(bus.overflow),  32'(m_ovf));
`ifdef PE_COLLECT_DROP_CNT_EN
        check("drop_cnt",  32'(bus.drop_cnt),  32'(m_drops));
`endif
    endtask

    // One clock cycle: drive inputs, advance the model with them, then compare after the edge.
    task automatic step(input logic r, input logic iv, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic rdy, input logic clr);
        logic             m_cap;
        logic             m_pop;
        logic             m_drop;
        logic [WIDTH-1:0] v;
        rst           = r;
        bus.in_valid  = iv;
        a             = av;
        b             = bv;
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        if (!r) begin
            q.delete();
            pend_due.delete();
            pend_val.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            m_cap  = (pend_due.size() != 0) && (pend_due[0] == cyc);
            m_pop  = (q.size() != 0) && rdy;
            m_drop = m_cap && (q.size() == DEPTH) && !m_pop;
            if (m_pop) begin
                $display("pop  cyc=%0d data=%04h", cyc, q[0]);
                void'(q.pop_front());
            end
            if (m_cap) begin
                v = pend_val.pop_front();
                void'(pend_due.pop_front());
                if (m_drop) $display("drop cyc=%0d data=%04h", cyc, v);
                else        q.push_back(v);
            end
            if (m_drop) begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end else if (clr) begin
                m_ovf = 1'b0;
            end
            if (iv) begin
                pend_due.push_back(cyc + LAT);
                pend_val.push_back(av + bv);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(1'b1, 1'b0, 16'($urandom), 16'($urandom), rdy, 1'b0);
    endtask

    // Issue one token and check that out_valid rises exactly LAT+1 cycles later.
    task automatic timed_token(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic [WIDTH-1:0] expv);
        step(1'b1, 1'b1, av, bv, 1'b1, 1'b0);
        idle(LAT - 1, 1'b1);
        check("lat_not_yet", 32'(bus.out_valid), 32'(0));
        idle(1, 1'b1);
        check("lat_valid", 32'(bus.out_valid), 32'(1));
        check("lat_data",  32'(bus.out_data),  32'(expv));
        idle(1, 1'b1);
        check("lat_one_beat", 32'(bus.empty), 32'(1));
    endtask

    initial begin
        // Reset held with in_valid asserted; nothing may be captured afterwards.
        repeat (3) step(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_empty",     32'(bus.empty),     32'(1));
        check("rst_count",     32'(bus.count),     32'(0));
        check("rst_overflow",  32'(bus.overflow),  32'(0));
        idle(LAT + 5, 1'b1);

        // Single token 00F0 + 0F00
        timed_token(16'h00F0, 16'h0F00, 16'h0FF0);
        idle(3, 1'b1);

        // Burst of 1..8 with the consumer stalled, then drain in order
        for (int k = 1; k <= 8; k++) step(1'b1, 1'b1, 16'(k), 16'h0000, 1'b0, 1'b0);
        idle(LAT + 2, 1'b0);
        check("burst_full",  32'(bus.full),     32'(1));
        check("burst_count", 32'(bus.count),    32'(8));
        check("burst_ovf",   32'(bus.overflow), 32'(0));
        idle(10, 1'b1);

        // Ten tokens into a stalled FIFO: the last two are dropped
        for (int k = 1; k <= 10; k++) step(1'b1, 1'b1, 16'(16'h0100 + k), 16'h0000, 1'b0, 1'b0);
        idle(LAT + 2, 1'b0);
        check("ovf_set", 32'(bus.overflow), 32'(1));
`ifdef PE_COLLECT_DROP_CNT_EN
        check("ovf_drop_cnt", 32'(bus.drop_cnt), 32'(2));
`endif
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(bus.overflow), 32'(0));
`ifdef PE_COLLECT_DROP_CNT_EN
        check("drop_cnt_kept", 32'(bus.drop_cnt), 32'(2));
`endif

        // FIFO still full: a capture lands in the same cycle as a pop
        step(1'b1, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
        idle(LAT - 1, 1'b0);
        idle(1, 1'b1);
        check("pp_count", 32'(bus.count),    32'(8));
        check("pp_ovf",   32'(bus.overflow), 32'(0));
        idle(12, 1'b1);

        // Reset mid-flight discards four in-flight tokens
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 16'(16'h0A00 + k), 16'h0000, 1'b1, 1'b0);
        idle(1, 1'b1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        idle(LAT + 5, 1'b1);
        timed_token(16'h1234, 16'h0001, 16'h1235);

        // Randomized traffic, occasional clears and resets
        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 9) < 6),
                 16'($urandom), 16'($urandom),
                 (n < 400) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 19) == 0));
        end
        idle(LAT + 12, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end
endmodule
